ccd_frame_capture: RTL and testbench

- Receive-side front end for the camera path: accepts the sensor's frame/line-valid pixel stream (FVAL/LVAL/DATA) and produces a qualified pixel stream with X/Y coordinates and a frame count.
- Downstream, this stream feeds the SDRAM write-port packing and address logic.
- It is the receiving end of the interface whose transmit end is the sensor output; display read-out stays in the VGA path.
- Start/stop control arms capture on frame boundaries only, so a partial frame is never written.

---
 rtl/ccd_pkg.sv | 17 +
 rtl/ccd_frame_capture_if.sv | 34 +++
 rtl/ccd_edge_sync.sv | 57 +++++
 rtl/ccd_frame_capture.sv | 162 ++++++++++++++++
 tb/tb_ccd_frame_capture.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ccd_pkg.sv
// Shared constants and FSM state type for the camera receive front end.
// The pixel width is also consumed by the SDRAM write-port packing logic.
package ccd_pkg;

    localparam int CCD_DATA_W   = 12;
    localparam int CCD_H_ACTIVE = 640;
    localparam int CCD_V_ACTIVE = 480;
    localparam int CCD_CNT_W    = 16;
    localparam int CCD_FRAME_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_FS = 2'd1,
        ST_ACTIVE  = 2'd2
    } ccd_state_e;

endpackage

// File: rtl/ccd_frame_capture_if.sv
// Sensor-side inputs and qualified pixel outputs of the capture block.
// master = sensor/control side, slave = capture block.
interface ccd_frame_capture_if #(
    parameter int DATA_W  = ccd_pkg::CCD_DATA_W,
    parameter int CNT_W   = ccd_pkg::CCD_CNT_W,
    parameter int FRAME_W = ccd_pkg::CCD_FRAME_W
);

    logic               iFVAL;
    logic               iLVAL;
    logic [DATA_W-1:0]  iDATA;
    logic               iSTART;
    logic               iEND;

    logic [DATA_W-1:0]  oDATA;
    logic               oDVAL;
    logic [CNT_W-1:0]   oX_Cont;
    logic [CNT_W-1:0]   oY_Cont;
    logic [FRAME_W-1:0] oFrame_Cont;
    logic               oFRAME_DONE;
    logic               oLINE_ERR;
    logic               oBUSY;

    modport master (
        output iFVAL, iLVAL, iDATA, iSTART, iEND,
        input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oFRAME_DONE, oLINE_ERR, oBUSY
    );

    modport slave (
        input  iFVAL, iLVAL, iDATA, iSTART, iEND,
        output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oFRAME_DONE, oLINE_ERR, oBUSY
    );

endinterface

// File: rtl/ccd_edge_sync.sv
// Registers FVAL/LVAL/DATA once and flags frame start/end and line end; one cycle latency.
// No backpressure: the sensor pixel clock paces the stream.
module ccd_edge_sync
    import ccd_pkg::*;
#(
    parameter int   DATA_W        = CCD_DATA_W,
    parameter logic FVAL_PREV_RST = 1'b1,
    parameter logic LVAL_PREV_RST = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fval_i,
    input  logic              lval_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              fval_o,
    output logic              lval_o,
    output logic [DATA_W-1:0] data_o,
    output logic              fs_o,
    output logic              fe_o,
    output logic              le_o
);

    logic              fval_q;
    logic              lval_q;
    logic [DATA_W-1:0] data_q;
    logic              fval_prev_q;
    logic              lval_prev_q;
    logic              primed_q;

    // On the first cycle out of reset prev takes the raw input, so a level
    // already present at release never looks like an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            data_q      <= '0;
            fval_prev_q <= FVAL_PREV_RST;
            lval_prev_q <= LVAL_PREV_RST;
            primed_q    <= 1'b0;
        end else begin
            fval_q      <= fval_i;
            lval_q      <= lval_i;
            data_q      <= data_i;
            fval_prev_q <= primed_q ? fval_q : fval_i;
            lval_prev_q <= primed_q ? lval_q : lval_i;
            primed_q    <= 1'b1;
        end
    end

    assign fval_o = fval_q;
    assign lval_o = lval_q;
    assign data_o = data_q;
    assign fs_o   = fval_q & ~fval_prev_q;
    assign fe_o   = ~fval_q & fval_prev_q;
    assign le_o   = ~lval_q & lval_prev_q;

endmodule

// File: rtl/ccd_frame_capture.sv
// Qualifies the sensor FVAL/LVAL stream into (data, X, Y) beats with frame count; capture arms on frame edges only.
// iDATA->oDATA latency is 2 cycles; no backpressure, the sensor pixel clock paces everything.
module ccd_frame_capture
    import ccd_pkg::*;
#(
    parameter int DATA_W   = CCD_DATA_W,
    parameter int H_ACTIVE = CCD_H_ACTIVE,
    parameter int V_ACTIVE = CCD_V_ACTIVE,
    parameter int CNT_W    = CCD_CNT_W,
    parameter int FRAME_W  = CCD_FRAME_W
) (
    input  logic               iCLK,
    input  logic               iRST,
    ccd_frame_capture_if.slave bus
);

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] X_OVF  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_OVF  = CNT_W'(V_ACTIVE);

    logic              m_fval;
    logic              m_lval;
    logic [DATA_W-1:0] m_data;
    logic              fs;
    logic              fe;
    logic              le;

    ccd_state_e state_q, state_d;
    logic       stop_q, stop_d;
    logic       pix_vld;
    logic       frame_end;
    logic       row_end;

    logic [CNT_W-1:0]   x_q;
    logic [CNT_W-1:0]   y_q;
    logic [DATA_W-1:0]  data_q;
    logic               dval_q;
    logic [CNT_W-1:0]   ox_q;
    logic [CNT_W-1:0]   oy_q;
    logic [FRAME_W-1:0] frame_q;
    logic               done_q;
    logic               err_q;
    logic               busy_q;

    ccd_edge_sync #(
        .DATA_W        (DATA_W),
        .FVAL_PREV_RST (1'b1),
        .LVAL_PREV_RST (1'b0)
    ) u_sync (
        .clk_i  (iCLK),
        .rst_i  (iRST),
        .fval_i (bus.iFVAL),
        .lval_i (bus.iLVAL),
        .data_i (bus.iDATA),
        .fval_o (m_fval),
        .lval_o (m_lval),
        .data_o (m_data),
        .fs_o   (fs),
        .fe_o   (fe),
        .le_o   (le)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.iSTART && !bus.iEND) state_d = ST_WAIT_FS;
            end
            ST_WAIT_FS: begin
                if (bus.iEND)  state_d = ST_IDLE;
                else if (fs)   state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (bus.iEND) stop_d = 1'b1;
                // A stop request landing on the frame-end cycle still counts.
                if (fe) begin
                    state_d = (stop_q || bus.iEND) ? ST_IDLE : ST_WAIT_FS;
                    stop_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_vld   = 1'b0;
        frame_end = 1'b0;
        row_end   = 1'b0;
        if (state_q == ST_ACTIVE) begin
            pix_vld   = m_fval & m_lval;
            frame_end = fe;
            row_end   = le & (x_q != '0);
        end
    end

    // x_q/y_q hold the position of the next pixel and may reach H/V_ACTIVE;
    // a pixel arriving there is out of range: reported at the last column/row and flagged.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            dval_q  <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            frame_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            dval_q <= pix_vld;
            done_q <= frame_end;
            busy_q <= (state_d != ST_IDLE);

            if (pix_vld) begin
                data_q <= m_data;
                ox_q   <= (x_q == X_OVF) ? X_LAST : x_q;
                oy_q   <= (y_q == Y_OVF) ? Y_LAST : y_q;
            end

            if (fs || le)
                x_q <= '0;
            else if (pix_vld && x_q != X_OVF)
                x_q <= x_q + CNT_W'(1);

            if (fs)
                y_q <= '0;
            else if (row_end && y_q != Y_OVF)
                y_q <= y_q + CNT_W'(1);

            if (frame_end)
                frame_q <= frame_q + FRAME_W'(1);

            if (state_q == ST_IDLE && bus.iSTART)
                err_q <= 1'b0;
            else if (pix_vld && (x_q == X_OVF || y_q == Y_OVF))
                err_q <= 1'b1;
        end
    end

    assign bus.oDATA       = data_q;
    assign bus.oDVAL       = dval_q;
    assign bus.oX_Cont     = ox_q;
    assign bus.oY_Cont     = oy_q;
    assign bus.oFrame_Cont = frame_q;
    assign bus.oFRAME_DONE = done_q;
    assign bus.oLINE_ERR   = err_q;
    assign bus.oBUSY       = busy_q;

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Bench for ccd_frame_capture with an 8x4 active window and a 2-bit frame counter.
module tb_ccd_frame_capture;

    localparam int DW = 12;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 16;
    localparam int FW = 2;
    localparam int OBS_N = 4096;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    ccd_frame_capture_if #(.DATA_W(DW), .CNT_W(CW), .FRAME_W(FW)) bus ();

    ccd_frame_capture #(
        .DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW), .FRAME_W(FW)
    ) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed pixel log, written only by the monitor.
    logic [DW-1:0] obs_d [OBS_N];
    int            obs_x [OBS_N];
    int            obs_y [OBS_N];
    int            obs_c [OBS_N];
    int            obs_wr   = 0;
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (bus.oDVAL && obs_wr < OBS_N) begin
            obs_d[obs_wr] = bus.oDATA;
            obs_x[obs_wr] = int'(bus.oX_Cont);
            obs_y[obs_wr] = int'(bus.oY_Cont);
            obs_c[obs_wr] = cyc;
            obs_wr = obs_wr + 1;
        end
        if (bus.oFRAME_DONE) done_cnt = done_cnt + 1;
    end

    typedef struct {
        logic [DW-1:0] d;
        int            x;
        int            y;
    } pix_t;

    // pulse: 0 none, 1 iSTART, 2 iEND, 3 both; end_line: line index carrying an iEND pulse (-1 none)
    typedef struct {
        int pulse; int lines; int ppl; int long_line; int long_len; int end_line; int seq;
        int cap; int fc; int err_pre; int err; int busy;
    } vec_t;

    pix_t exp_q [$];
    vec_t vecs [11];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   obs_rd = 0;
    int   done_seen = 0;
    int   m_fc;
    int   m_err;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tot++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap_pulse(input int pulse);
        bus.iSTART = (pulse == 1 || pulse == 3);
        bus.iEND   = (pulse == 2 || pulse == 3);
        tick();
        bus.iSTART = 1'b0;
        bus.iEND   = 1'b0;
        tick();
        tick();
    endtask

    task automatic idle_line(input int n);
        for (int p = 0; p < n; p++) begin
            bus.iLVAL = 1'b1;
            bus.iDATA = DW'($urandom);
            tick();
        end
        bus.iLVAL = 1'b0;
        repeat (2) tick();
    endtask

    // Drives one frame; when cap is set, the expected pixel stream is queued:
    // column/row clamp at the last active position.
    task automatic run_frame(input int lines, input int ppl, input int long_line, input int long_len,
                             input int end_line, input int seq, input int cap, output int first_cyc);
        first_cyc = -1;
        bus.iFVAL = 1'b1;
        repeat (int'($urandom_range(4, 2))) tick();
        for (int l = 0; l < lines; l++) begin
            int n;
            n = (l == long_line) ? long_len : ppl;
            for (int p = 0; p < n; p++) begin
                logic [DW-1:0] d;
                d = (seq != 0) ? DW'(l * ppl + p) : DW'($urandom);
                bus.iLVAL = 1'b1;
                bus.iDATA = d;
                bus.iEND  = (l == end_line && p == 0);
                if (first_cyc < 0) first_cyc = cyc;
                if (cap != 0) exp_q.push_back('{d, (p < H) ? p : H - 1, (l < V) ? l : V - 1});
                tick();
            end
            bus.iLVAL = 1'b0;
            bus.iEND  = 1'b0;
            repeat (int'($urandom_range(3, 1))) tick();
        end
        bus.iFVAL = 1'b0;
        repeat (5) tick();
    endtask

    task automatic check_frame(input string tag, input int first_cyc, input int exp_done,
                               input int exp_fc, input int exp_err, input int exp_busy);
        int nexp;
        int nobs;
        nexp = exp_q.size();
        nobs = obs_wr - obs_rd;
        chk({tag, " pixel count"}, nobs, nexp);
        for (int i = 0; i < nexp && i < nobs; i++)
            chk({tag, " pixel {data,x,y}"},
                {obs_d[obs_rd + i], 16'(obs_x[obs_rd + i]), 16'(obs_y[obs_rd + i])},
                {exp_q[i].d, 16'(exp_q[i].x), 16'(exp_q[i].y)});
        if (nexp > 0 && nobs > 0)
            chk({tag, " first pixel latency"}, obs_c[obs_rd] - first_cyc, 2);
        obs_rd = obs_wr;
        exp_q.delete();
        chk({tag, " frame done pulses"}, done_cnt - done_seen, exp_done);
        done_seen = done_cnt;
        chk({tag, " oFrame_Cont"}, bus.oFrame_Cont, exp_fc);
        chk({tag, " oLINE_ERR"}, bus.oLINE_ERR, exp_err);
        chk({tag, " oBUSY"}, bus.oBUSY, exp_busy);
    endtask

    initial begin
        int first;

        //           pulse lines ppl long len end seq  cap fc ep err busy
        vecs[0]  = '{1,    4,    8,  -1,  0,  -1, 1,   1,  1, 0, 0,  1};
        vecs[1]  = '{0,    4,    8,  -1,  0,  -1, 0,   1,  2, 0, 0,  1};
        vecs[2]  = '{0,    4,    8,  -1,  0,   1, 0,   1,  3, 0, 0,  0};
        vecs[3]  = '{0,    4,    8,  -1,  0,  -1, 0,   0,  3, 0, 0,  0};
        vecs[4]  = '{3,    4,    8,  -1,  0,  -1, 0,   0,  3, 0, 0,  0};
        vecs[5]  = '{1,    4,    8,   1, 10,  -1, 0,   1,  0, 0, 1,  1};
        vecs[6]  = '{0,    4,    8,  -1,  0,  -1, 0,   1,  1, 1, 1,  1};
        vecs[7]  = '{2,    4,    8,  -1,  0,  -1, 0,   0,  1, 1, 1,  0};
        vecs[8]  = '{1,    5,    8,  -1,  0,  -1, 0,   1,  2, 0, 1,  1};
        vecs[9]  = '{0,    3,    6,  -1,  0,   0, 0,   1,  3, 1, 1,  0};
        vecs[10] = '{1,    4,    8,  -1,  0,  -1, 0,   1,  0, 0, 0,  1};

        rst        = 1'b1;
        bus.iFVAL  = 1'b0;
        bus.iLVAL  = 1'b0;
        bus.iDATA  = '0;
        bus.iSTART = 1'b0;
        bus.iEND   = 1'b0;
        repeat (3) tick();
        chk("reset oDVAL", bus.oDVAL, 0);
        chk("reset oDATA", bus.oDATA, 0);
        chk("reset oX_Cont", bus.oX_Cont, 0);
        chk("reset oY_Cont", bus.oY_Cont, 0);
        chk("reset oFrame_Cont", bus.oFrame_Cont, 0);
        chk("reset oFRAME_DONE", bus.oFRAME_DONE, 0);
        chk("reset oLINE_ERR", bus.oLINE_ERR, 0);
        chk("reset oBUSY", bus.oBUSY, 0);
        rst = 1'b0;
        repeat (2) tick();

        for (int r = 0; r < 11; r++) begin
            gap_pulse(vecs[r].pulse);
            chk($sformatf("row%0d oLINE_ERR before frame", r), bus.oLINE_ERR, vecs[r].err_pre);
            if (vecs[r].pulse == 3)
                chk($sformatf("row%0d oBUSY after start+end", r), bus.oBUSY, 0);
            run_frame(vecs[r].lines, vecs[r].ppl, vecs[r].long_line, vecs[r].long_len,
                      vecs[r].end_line, vecs[r].seq, vecs[r].cap, first);
            check_frame($sformatf("row%0d", r), first, vecs[r].cap, vecs[r].fc,
                        vecs[r].err, vecs[r].busy);
        end

        // Free-running capture of random-geometry frames.
        m_fc  = vecs[10].fc;
        m_err = vecs[10].err;
        for (int f = 0; f < 6; f++) begin
            int nl;
            int np;
            nl = int'($urandom_range(5, 1));
            np = int'($urandom_range(10, 1));
            run_frame(nl, np, -1, 0, -1, 0, 1, first);
            m_fc = (m_fc + 1) % (1 << FW);
            if (np > H || nl > V) m_err = 1;
            check_frame($sformatf("rand%0d", f), first, 1, m_fc, m_err, 1);
        end

        // Reset in the middle of a frame, then arm while FVAL is still high.
        gap_pulse(2);
        chk("stop while waiting oBUSY", bus.oBUSY, 0);
        bus.iFVAL = 1'b1;
        repeat (3) tick();
        idle_line(8);
        rst = 1'b1;
        tick();
        tick();
        chk("mid-frame reset oBUSY", bus.oBUSY, 0);
        chk("mid-frame reset oFrame_Cont", bus.oFrame_Cont, 0);
        chk("mid-frame reset oLINE_ERR", bus.oLINE_ERR, 0);
        rst = 1'b0;
        tick();
        bus.iSTART = 1'b1;
        tick();
        bus.iSTART = 1'b0;
        tick();
        chk("armed mid-frame oBUSY", bus.oBUSY, 1);
        idle_line(8);
        idle_line(8);
        bus.iFVAL = 1'b0;
        repeat (5) tick();
        check_frame("partial frame after reset", -1, 0, 0, 0, 1);
        run_frame(4, 8, -1, 0, -1, 0, 1, first);
        check_frame("first full frame after reset", first, 1, 1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
